// File: rtl/aes_pkg.sv
// AES-128 shared types, S-box table and GF(2^8) helpers.
// Used by aes_round_engine and its aes_round datapath.
package aes_pkg;

  localparam int NB = 4;
  localparam int NK = 4;
  localparam int NR = 10;

  // byte 0 of the block lives in [15], i.e. bits [127:120]
  typedef logic [15:0][7:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } fsm_e;

  // S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // one column, row 0 in the top byte
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows,
// MixColumns (skipped when last_round) and AddRoundKey.
module aes_round (
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  input  logic         last_round,
  output logic [127:0] state_o
);
  import aes_pkg::*;

  state_t      st;
  state_t      sb;
  state_t      sr;
  logic [127:0] mc;
  logic [31:0]  col;

  // byte i = row (i%4), column (i/4); row r rotates left by r
  always_comb begin
    st  = state_t'(state_i);
    sb  = '0;
    sr  = '0;
    mc  = '0;
    col = '0;
    for (int i = 0; i < 16; i++) begin
      sb[15 - i] = sbox(st[15 - i]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[15 - (r + 4 * c)] = sb[15 - (r + 4 * ((c + r) & 3))];
      end
    end
    for (int c = 0; c < 4; c++) begin
      col = {sr[15 - 4 * c], sr[14 - 4 * c],
             sr[13 - 4 * c], sr[12 - 4 * c]};
      mc[127 - 32 * c -: 32] = last_round ? col : mix_column(col);
    end
    state_o = mc ^ key_i;
  end

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryptor, one round per enabled cycle.
// Define AES_KEY_LATCH_EN to snapshot the round keys at input fire.
module aes_round_engine #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] rkey [0:NR],
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);
  import aes_pkg::*;

  fsm_e         fsm_q;
  logic [3:0]   rnd_q;
  logic [127:0] state_q;
  logic         ovalid_q;
  logic [127:0] round_d;
  logic [127:0] rk_sel;
  logic [127:0] key_use [0:NR];
  logic         fire;

  assign fire      = in_valid & in_ready;
  assign in_ready  = (fsm_q == IDLE) & en;
  assign out_valid = ovalid_q & en;
  assign data_out  = state_q;

`ifdef AES_KEY_LATCH_EN
  logic [127:0] key_q [0:NR];

  // snapshot the whole key schedule when a block is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r <= NR; r++) key_q[r] <= '0;
    end else if (fire) begin
      for (int r = 0; r <= NR; r++) key_q[r] <= rkey[r];
    end
  end

  assign key_use = key_q;
`else
  assign key_use = rkey;
`endif

  // in FINAL rnd_q has reached NR, so one mux covers all rounds
  always_comb begin
    rk_sel = '0;
    for (int r = 0; r <= NR; r++) begin
      if (rnd_q == 4'(r)) rk_sel = key_use[r];
    end
  end

  aes_round u_round (
    .state_i    (state_q),
    .key_i      (rk_sel),
    .last_round (fsm_q == FINAL),
    .state_o    (round_d)
  );

  // control FSM with round counter, state and registered out_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q    <= IDLE;
      rnd_q    <= '0;
      state_q  <= '0;
      ovalid_q <= 1'b0;
    end else if (en) begin
      unique case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= data_in ^ rkey[0];
            rnd_q   <= 4'd1;
            fsm_q   <= ROUND;
          end
        end
        ROUND: begin
          state_q <= round_d;
          rnd_q   <= rnd_q + 4'd1;
          if (rnd_q == 4'(NR - 1)) fsm_q <= FINAL;
        end
        FINAL: begin
          state_q  <= round_d;
          ovalid_q <= 1'b1;
          fsm_q    <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            ovalid_q <= 1'b0;
            fsm_q    <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_engine.sv
// Self-checking bench for aes_round_engine: FIPS-197 vectors,
// backpressure, mid-run reset, clock-enable gaps, key latching.
module tb_aes_round_engine;
  import aes_pkg::*;

  localparam int R = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [127:0] rkey [0:R];
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  logic [127:0] ks [0:R];
  logic [127:0] sb_q [$];
  int           checks   = 0;
  int           failures = 0;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    bit           gap;
    bit           early;
  } vec_t;

  vec_t tbl [4];

  always #5 clk = ~clk;

  aes_round_engine #(.NR(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .rkey      (rkey),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rcon(input int i);
    case (i)
      1: return 8'h01;
      2: return 8'h02;
      3: return 8'h04;
      4: return 8'h08;
      5: return 8'h10;
      6: return 8'h20;
      7: return 8'h40;
      8: return 8'h80;
      9: return 8'h1b;
      default: return 8'h36;
    endcase
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]),
             sbox(t[15:8]), sbox(t[7:0])} ^ {rcon(i / 4), 24'h0};
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r <= R; r++)
      ks[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  task automatic run_block(input logic [127:0] pt, input logic [127:0] ct,
                           input bit gap, input bit early, input bit bp,
                           input bit zkey, input string nm);
    int           n;
    logic [127:0] held;
    rkey      = ks;
    data_in   = pt;
    in_valid  = 1'b1;
    out_ready = early;
    chk({nm, ".in_ready"}, 128'(in_ready), 128'd1);
    step();
    sb_q.push_back(ct);
    in_valid = 1'b0;
    data_in  = '1;
    n        = 1;
    if (zkey) begin
      for (int r = 0; r <= R; r++) rkey[r] = '0;
    end
    while (!out_valid && n < 40) begin
      en = !(gap && n >= 4 && n <= 6);
      step();
      if (!en) chk({nm, ".en_gate"}, 128'({out_valid, in_ready}), 128'd0);
      n++;
    end
    en = 1'b1;
    chk({nm, ".latency"}, 128'(n), gap ? 128'd14 : 128'd11);
    held = data_out;
    if (bp) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      data_in   = pt ^ 128'h1;
      repeat (5) begin
        step();
        chk({nm, ".bp_hold"}, data_out, held);
        chk({nm, ".bp_flags"}, 128'({out_valid, in_ready}), 128'd2);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s.sb_empty got=%h exp=<queued>", nm, held);
    end else begin
      checks--;
      chk({nm, ".data"}, held, sb_q.pop_front());
    end
    out_ready = 1'b0;
    chk({nm, ".idle"}, 128'({out_valid, in_ready}), 128'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{KEY_B, PT_B, CT_B, 1'b0, 1'b0};
    tbl[1] = '{KEY_C, PT_C, CT_C, 1'b0, 1'b1};
    tbl[2] = '{KEY_B, PT_B, CT_B, 1'b1, 1'b0};
    tbl[3] = '{KEY_C, PT_C, CT_C, 1'b1, 1'b1};

    rst       = 1'b1;
    en        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    for (int r = 0; r <= R; r++) rkey[r] = '0;
    #1;
    chk("rst.out_valid", 128'(out_valid), 128'd0);
    chk("rst.data_out", data_out, 128'd0);
    repeat (2) step();
    rst = 1'b0;
    chk("rst.in_ready", 128'(in_ready), 128'd1);

    expand(KEY_B);
    chk("keyexp.rk10", ks[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    for (int v = 0; v < 4; v++) begin
      expand(tbl[v].key);
      run_block(tbl[v].pt, tbl[v].ct, tbl[v].gap, tbl[v].early,
                1'b0, 1'b0, $sformatf("vec%0d", v));
    end

    expand(KEY_B);
    run_block(PT_B, CT_B, 1'b0, 1'b0, 1'b1, 1'b0, "bp");

    rkey     = ks;
    data_in  = PT_B;
    in_valid = 1'b1;
    step();
    sb_q.push_back(CT_B);
    in_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("midrst.out_valid", 128'(out_valid), 128'd0);
    chk("midrst.data_out", data_out, 128'd0);
    sb_q.delete();
    step();
    rst = 1'b0;
    run_block(PT_B, CT_B, 1'b0, 1'b0, 1'b0, 1'b0, "after_rst");

`ifdef AES_KEY_LATCH_EN
    expand(KEY_B);
    run_block(PT_B, CT_B, 1'b0, 1'b0, 1'b0, 1'b1, "key_latch");
`endif

    chk("sb.drained", 128'(sb_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
